// File: rtl/analog_probe_scanner.sv
// Round-robin analog probe scanner. It samples potential or flow on named nodes,
// quantises each sample to a saturating signed code and queues it in a FWFT FIFO.
module analog_probe_scanner #(
    parameter int  NUM_CHANNELS    = 4,
    parameter int  DATA_WIDTH      = 16,
    parameter int  FIFO_DEPTH      = 8,
    parameter int  SETTLE_CYCLES   = 2,
    parameter real VOLT_FULL_SCALE = 1.0,
    parameter real CURR_FULL_SCALE = 1.0e-3,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [NUM_CHANNELS-1:0]      chan_enable,
    input  logic [NUM_CHANNELS-1:0]      chan_mode,
    output logic                         busy,
    output logic                         scan_done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH_W-1:0]              out_channel,
    output logic signed [DATA_WIDTH-1:0] out_code,
    output logic                         out_invalid,
    output logic                         out_saturated,
    output logic [15:0]                  overflow_count
);

    localparam int     IDX_W       = $clog2(NUM_CHANNELS + 1);
    localparam int     AW          = $clog2(FIFO_DEPTH);
    localparam int     CNT_W       = AW + 1;
    localparam int     SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam longint CODE_MAX    = (longint'(1) <<< (DATA_WIDTH - 1)) - 1;
    localparam longint CODE_MIN    = -CODE_MAX - 1;
    localparam int     SIM_NODES   = 16;

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_SAMPLE, S_PUSH} state_t;

    typedef struct packed {
        logic                         invalid;
        logic                         saturated;
        logic signed [DATA_WIDTH-1:0] code;
    } sample_t;

    typedef struct packed {
        logic [CH_W-1:0] channel;
        sample_t         smp;
    } entry_t;

    // Node names are written by the test. The sim_node_* table stands in for the
    // simulator's analog node database that the fetch routines consult.
    string node_to_probe      [NUM_CHANNELS];
    string sim_node_name      [SIM_NODES];
    real   sim_node_potential [SIM_NODES];
    real   sim_node_flow      [SIM_NODES];

    function automatic string quantity_name(input logic flow);
        if (flow) return "flow";
        return "potential";
    endfunction

    function automatic logic analog_is_valid(input string node, input string quantity);
        logic ok;
        ok = 1'b0;
        if (node != "" && (quantity == "potential" || quantity == "flow")) begin
            for (int i = 0; i < SIM_NODES; i++) begin
                if (sim_node_name[i] == node) ok = 1'b1;
            end
        end
        return ok;
    endfunction

    function automatic real analog_get_value(input string node, input string quantity);
        real v;
        v = 0.0;
        for (int i = 0; i < SIM_NODES; i++) begin
            if (sim_node_name[i] == node)
                v = (quantity == "flow") ? sim_node_flow[i] : sim_node_potential[i];
        end
        return v;
    endfunction

    function automatic real round_half_away(input real x);
        if (x >= 0.0) return $floor(x + 0.5);
        return -$floor(-x + 0.5);
    endfunction

    function automatic sample_t saturate(input real rounded);
        sample_t s;
        s.invalid = 1'b0;
        if (rounded > real'(CODE_MAX)) begin
            s.code      = DATA_WIDTH'(CODE_MAX);
            s.saturated = 1'b1;
        end else if (rounded < real'(CODE_MIN)) begin
            s.code      = DATA_WIDTH'(CODE_MIN);
            s.saturated = 1'b1;
        end else begin
            s.code      = DATA_WIDTH'(longint'(rounded));
            s.saturated = 1'b0;
        end
        return s;
    endfunction

    function automatic sample_t take_sample(input string node, input logic flow);
        sample_t s;
        real     fs;
        fs = flow ? CURR_FULL_SCALE : VOLT_FULL_SCALE;
        if (analog_is_valid(node, quantity_name(flow))) begin
            s = saturate(round_half_away(
                    analog_get_value(node, quantity_name(flow)) / fs * real'(CODE_MAX)));
        end else begin
            s         = '0;
            s.invalid = 1'b1;
        end
        return s;
    endfunction

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx;
    logic [CH_W-1:0]   ch_lat, sel_ch;
    logic              mode_lat, sel_found;
    logic [7:0]        settle_cnt;
    logic              busy_d, done_d, push_req;
    sample_t           samp_p1;

    // Lowest enabled channel at or above the scan index.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (chan_enable[i] && (i >= int'(idx))) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_SELECT;
            S_SELECT: begin
                if (sel_found)       state_n = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
                else if (continuous) state_n = S_SELECT;
                else                 state_n = S_IDLE;
            end
            S_SETTLE: if (settle_cnt == 8'(SETTLE_LAST)) state_n = S_SAMPLE;
            S_SAMPLE: state_n = S_PUSH;
            S_PUSH:   state_n = S_SELECT;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d   = (state_n != S_IDLE);
        done_d   = (state == S_SELECT) && !sel_found;
        push_req = (state == S_PUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            ch_lat     <= '0;
            mode_lat   <= 1'b0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            busy      <= busy_d;
            scan_done <= done_d;
            case (state)
                S_IDLE: if (start) idx <= '0;
                S_SELECT: begin
                    if (sel_found) begin
                        ch_lat     <= sel_ch;
                        mode_lat   <= chan_mode[sel_ch];
                        settle_cnt <= '0;
                    end else begin
                        idx <= '0;
                    end
                end
                S_SETTLE: settle_cnt <= settle_cnt + 8'd1;
                S_PUSH:   idx <= IDX_W'(ch_lat) + IDX_W'(1);
                default:  ;
            endcase
        end
    end

    // Sample stage: fetch and quantise the latched channel
    always_ff @(posedge clk) begin
        if (state == S_SAMPLE) begin
            samp_p1 <= take_sample(node_to_probe[ch_lat], mode_lat);
            if (!analog_is_valid(node_to_probe[ch_lat], quantity_name(mode_lat)))
                $warning("%m: channel %0d node \"%s\" failed %s validity check",
                         ch_lat, node_to_probe[ch_lat], quantity_name(mode_lat));
        end
    end

    entry_t           fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0] count, count_n;
    logic             pop, push, full, bypass;
    entry_t           push_entry, head_n;

    // A pop in the same cycle frees a slot for a push into a full FIFO.
    always_comb begin
        pop        = out_valid & out_ready;
        full       = (count == CNT_W'(FIFO_DEPTH));
        push       = push_req & (~full | pop);
        rd_ptr_n   = rd_ptr + AW'(pop);
        count_n    = count + CNT_W'(push) - CNT_W'(pop);
        bypass     = push & (count == CNT_W'(pop));
        push_entry = {ch_lat, samp_p1};
        head_n     = bypass ? push_entry : fifo_mem[rd_ptr_n];
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    // Push/pop stage: pointers, registered head and overflow counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            out_valid      <= 1'b0;
            out_channel    <= '0;
            out_code       <= '0;
            out_invalid    <= 1'b0;
            out_saturated  <= 1'b0;
            overflow_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            if (count_n != '0) begin
                out_valid     <= 1'b1;
                out_channel   <= head_n.channel;
                out_code      <= head_n.smp.code;
                out_invalid   <= head_n.smp.invalid;
                out_saturated <= head_n.smp.saturated;
            end else begin
                out_valid <= 1'b0;
            end
            if (push_req && !push && overflow_count != 16'hFFFF)
                overflow_count <= overflow_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_analog_probe_scanner.sv
// Directed bench for analog_probe_scanner: timing, conversion, FIFO and reset cases.
module tb_analog_probe_scanner;

    logic              clk = 1'b0;
    logic              rst_n, start, continuous, out_ready;
    logic [3:0]        chan_enable, chan_mode;
    logic              busy, scan_done, out_valid, out_invalid, out_saturated;
    logic [1:0]        out_channel;
    logic signed [15:0] out_code;
    logic [15:0]       overflow_count;

    int checks = 0;
    int errors = 0;

    analog_probe_scanner dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .continuous     (continuous),
        .chan_enable    (chan_enable),
        .chan_mode      (chan_mode),
        .busy           (busy),
        .scan_done      (scan_done),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_channel    (out_channel),
        .out_code       (out_code),
        .out_invalid    (out_invalid),
        .out_saturated  (out_saturated),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pop_head();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cycles);
        cycles = -1;
        for (int i = 1; i <= bound; i++) begin
            tick(1);
            if (scan_done) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic check_head(input string tag, input int ch, input int code,
                              input int inv, input int sat);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_ch"}, out_channel, ch);
        check({tag, "_code"}, out_code, code);
        check({tag, "_inv"}, out_invalid, inv);
        check({tag, "_sat"}, out_saturated, sat);
    endtask

    initial begin
        int cyc;
        int n;
        int last_ch;
        int exp_ch [4];
        logic seen_done, seen_valid, seen_busy;

        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; out_ready = 1'b0;
        chan_enable = '0; chan_mode = '0;
        dut.sim_node_name[0] = "vin";   dut.sim_node_potential[0] = 0.5;
        dut.sim_node_name[1] = "iflow"; dut.sim_node_potential[1] = 0.0;
        dut.sim_node_flow[1] = -2.0e-3;
        dut.sim_node_name[2] = "vneg";  dut.sim_node_potential[2] = -0.25;
        dut.node_to_probe[0] = "vin";
        dut.node_to_probe[1] = "iflow";
        dut.node_to_probe[2] = "";
        dut.node_to_probe[3] = "vneg";
        tick(2);

        check("rst_busy", busy, 0);
        check("rst_done", scan_done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ch", out_channel, 0);
        check("rst_code", out_code, 0);
        check("rst_inv", out_invalid, 0);
        check("rst_sat", out_saturated, 0);
        check("rst_ovf", overflow_count, 0);
        rst_n = 1'b1;
        tick(1);

        // Single channel, 0.5 V -> 16384, done 6 cycles after start
        chan_enable = 4'b0001;
        pulse_start();
        check("a_busy_start", busy, 1);
        wait_done(20, cyc);
        check("a_latency", cyc, 6);
        check("a_busy_end", busy, 0);
        check_head("a_head", 0, 16384, 0, 0);
        pop_head();
        check("a_done_pulse", scan_done, 0);
        check("a_empty", out_valid, 0);

        // Flow clip on ch1, invalid node on ch2
        chan_enable = 4'b0110;
        chan_mode   = 4'b0010;
        pulse_start();
        wait_done(40, cyc);
        check("b_latency", cyc, 11);
        check_head("b_ch1", 1, -32768, 0, 1);
        pop_head();
        check_head("b_ch2", 2, 0, 1, 0);
        pop_head();
        check("b_empty", out_valid, 0);

        // Sparse enable over two continuous passes: ch1, ch3, ch1, ch3
        chan_enable = 4'b1010;
        chan_mode   = 4'b0000;
        continuous  = 1'b1;
        pulse_start();
        wait_done(40, cyc);
        check("c_pass1", cyc, 11);
        continuous = 1'b0;
        wait_done(40, cyc);
        check("c_pass2", cyc, 11);
        check("c_idle", busy, 0);
        exp_ch = '{1, 3, 1, 3};
        for (int i = 0; i < 4; i++) begin
            check("c_order_valid", out_valid, 1);
            check("c_order_ch", out_channel, exp_ch[i]);
            check("c_order_code", out_code, (exp_ch[i] == 3) ? -8192 : 0);
            pop_head();
        end
        check("c_empty", out_valid, 0);

        // Fill the FIFO with consumer stalled; 9th sample overflows
        chan_enable = 4'b1111;
        continuous  = 1'b1;
        pulse_start();
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (overflow_count != 0) begin
                n = i;
                break;
            end
        end
        check("d_first_ovf_cycle", n, 47);
        check("d_ovf1", overflow_count, 1);
        check_head("d_stable1", 0, 16384, 0, 0);
        tick(5);
        check("d_ovf2", overflow_count, 2);
        check_head("d_stable2", 0, 16384, 0, 0);

        // Pop during PUSH into a full FIFO: accepted, no overflow
        tick(4);
        out_ready = 1'b1;
        tick(1);
        out_ready  = 1'b0;
        continuous = 1'b0;
        check("e_ovf_same", overflow_count, 2);
        check("e_new_head", out_channel, 1);
        wait_done(40, cyc);
        check("e_done", cyc, 6);
        check("e_ovf_next", overflow_count, 3);
        n = 0;
        last_ch = -1;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid) break;
            last_ch = int'(out_channel);
            pop_head();
            n++;
        end
        check("e_occupancy", n, 8);
        check("e_last_ch", last_ch, 2);

        // Reset while ch2 settles with one entry queued
        chan_enable = 4'b0101;
        pulse_start();
        tick(6);
        check("f_pre_valid", out_valid, 1);
        check("f_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("f_rst_busy", busy, 0);
        check("f_rst_valid", out_valid, 0);
        check("f_rst_ovf", overflow_count, 0);
        check("f_rst_code", out_code, 0);
        check("f_rst_done", scan_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0; seen_valid = 1'b0; seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            seen_done  |= scan_done;
            seen_valid |= out_valid;
            seen_busy  |= busy;
        end
        check("f_no_done", seen_done, 0);
        check("f_no_entry", seen_valid, 0);
        check("f_no_busy", seen_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
